cache_data_array: RTL
=====================

CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

Interface
REQ-001 Parameter CHANNELS, default 4: ways per set.
REQ-002 Parameter AINDEX_WIDTH, default 8: set index width; BANKS = 2**AINDEX_WIDTH.
REQ-003 Parameter CH_NUM_WIDTH, default 2: way-select width.
REQ-004 Parameter CACHE_STR_WIDTH, default 128: line width, bits.
REQ-005 Parameter WORD_WIDTH, default 32: CPU word width; WORDS = CACHE_STR_WIDTH/WORD_WIDTH; OFFSET_WIDTH = clog2(WORDS).
REQ-006 Parameter BEAT_WIDTH, default 32: fill beat width; BEATS = CACHE_STR_WIDTH/BEAT_WIDTH.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 not_reset  in  1  reset, synchronous, active-low.
REQ-009 req_valid  in  1  CPU access request.
REQ-010 req_ready  out  1  request acceptance; accepted when req_valid && req_ready.
REQ-011 req_write  in  1  1 = byte-masked word write, 0 = word read.
REQ-012 req_index  in  AINDEX_WIDTH; req_channel  in  CH_NUM_WIDTH; req_offset  in  OFFSET_WIDTH  word address.
REQ-013 req_wdata  in  WORD_WIDTH; req_be  in  WORD_WIDTH/8  write data, byte enables (bit k -> byte k).
REQ-014 rsp_valid  out  1; rsp_rdata  out  WORD_WIDTH  response.
REQ-015 fill_start  in  1; fill_index  in  AINDEX_WIDTH; fill_channel  in  CH_NUM_WIDTH  line-fill start.
REQ-016 fill_beat_valid  in  1; fill_beat_data  in  BEAT_WIDTH  fill beat.
REQ-017 fill_busy  out  1; fill_done  out  1  fill status.

Function
REQ-018 Storage SHALL be BANKS x CHANNELS lines of CACHE_STR_WIDTH bits; word w occupies bits [w*WORD_WIDTH +: WORD_WIDTH].
REQ-019 req_ready SHALL equal 1 in IDLE, 0 otherwise, decoded from fill state only (no combinational path from req_valid).
REQ-020 Accepted read: rsp_valid=1 exactly one cycle later, rsp_rdata = addressed word as stored before that edge.
REQ-021 Accepted write: bytes with req_be=1 updated at the accepting edge, others unchanged; next cycle rsp_valid=1, rsp_rdata = merged word.
REQ-022 rsp_valid SHALL be 0 in every cycle not following an acceptance; rsp_rdata holds its last value.
REQ-023 Back-to-back accesses at 1/cycle; read immediately after a write to same word returns written data.
REQ-024 req_channel >= CHANNELS: write dropped, read returns 0, rsp_valid still pulses.
REQ-025 Fill FSM states IDLE, FILL, DONE; IDLE->FILL on fill_start (captures fill_index, fill_channel, beat counter=0).
REQ-026 In FILL each fill_beat_valid writes beat n to bits [n*BEAT_WIDTH +: BEAT_WIDTH] of captured line, counter+1; beat BEATS-1 -> DONE.
REQ-027 DONE lasts one cycle, fill_done=1 only there, then IDLE; fill_busy=1 in FILL and DONE.
REQ-028 fill_start outside IDLE ignored; fill_beat_valid outside FILL ignored (including same cycle as fill_start).
REQ-029 Access and fill_start both in IDLE same cycle: access executes that cycle, fill begins next.
REQ-030 Elaboration SHALL fail unless CACHE_STR_WIDTH divisible by WORD_WIDTH and BEAT_WIDTH, WORD_WIDTH divisible by 8, CHANNELS <= 2**CH_NUM_WIDTH.

Reset
REQ-031 not_reset=0 at an edge: all lines zeroed, FSM IDLE, counter 0, rsp_valid=0, rsp_rdata=0, fill_done=0, fill_busy=0.
REQ-032 Reset mid-fill abandons fill; no later beat written; accesses in reset cycle discarded.

Structure
REQ-033 Shared cache package holds default parameter constants and fill state encoding (IDLE=0, FILL=1, DONE=2).
REQ-034 Sub-module cache_fill_ctrl implements FSM and beat counter; array, byte merge, response register in top.

Verification
REQ-035 Reset, read idx 0x10 ch 2 off 3 -> rsp_valid next cycle, rsp_rdata=0.
REQ-036 Write 0xAABBCCDD be=4'b0101 idx 0x10 ch 1 off 0 over 0x11223344 -> rsp_rdata 0x11BB33DD; read-back same.
REQ-037 fill_start idx 0xFF ch 3, beats 0x0,0x1,0x2,0x3 with one idle gap -> fill_done once after 4th beat; off 2 reads 0x2; req_ready=0 in FILL/DONE.
REQ-038 fill_start plus read same IDLE cycle -> read responds next cycle, fill_busy rises next cycle; fill_start during FILL ignored.
REQ-039 not_reset=0 after 2 beats -> IDLE, line zero, later beats ignored, fill_done never asserted.

Source files
------------

// File: rtl/cache_data_array_pkg.sv
// cache_data_array_pkg: shared defaults, fill state encoding and width helper for the cache data array
package cache_data_array_pkg;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_AINDEX_WIDTH = 8;
    localparam int DEF_CH_NUM_WIDTH = 2;
    localparam int DEF_CACHE_STR_WIDTH = 128;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_BEAT_WIDTH = 32;
    localparam int DEF_OFFSET_WIDTH = $clog2(DEF_CACHE_STR_WIDTH / DEF_WORD_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cache_data_array_if.sv
// cache_data_array_if: CPU word-access and line-fill signals of the cache data array
interface cache_data_array_if #(
    parameter int AINDEX_WIDTH = cache_data_array_pkg::DEF_AINDEX_WIDTH,
    parameter int CH_NUM_WIDTH = cache_data_array_pkg::DEF_CH_NUM_WIDTH,
    parameter int OFFSET_WIDTH = cache_data_array_pkg::DEF_OFFSET_WIDTH,
    parameter int WORD_WIDTH = cache_data_array_pkg::DEF_WORD_WIDTH,
    parameter int BEAT_WIDTH = cache_data_array_pkg::DEF_BEAT_WIDTH
);
    logic req_valid;
    logic req_ready;
    logic req_write;
    logic [AINDEX_WIDTH-1:0] req_index;
    logic [CH_NUM_WIDTH-1:0] req_channel;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic [WORD_WIDTH/8-1:0] req_be;
    logic rsp_valid;
    logic [WORD_WIDTH-1:0] rsp_rdata;
    logic fill_start;
    logic [AINDEX_WIDTH-1:0] fill_index;
    logic [CH_NUM_WIDTH-1:0] fill_channel;
    logic fill_beat_valid;
    logic [BEAT_WIDTH-1:0] fill_beat_data;
    logic fill_busy;
    logic fill_done;

    modport master (
        output req_valid, req_write, req_index, req_channel, req_offset, req_wdata, req_be,
        output fill_start, fill_index, fill_channel, fill_beat_valid, fill_beat_data,
        input req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done
    );

    modport slave (
        input req_valid, req_write, req_index, req_channel, req_offset, req_wdata, req_be,
        input fill_start, fill_index, fill_channel, fill_beat_valid, fill_beat_data,
        output req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: line-fill FSM, beat counter and captured fill target
module cache_fill_ctrl
    import cache_data_array_pkg::*;
#(
    parameter int AINDEX_WIDTH = DEF_AINDEX_WIDTH,
    parameter int CH_NUM_WIDTH = DEF_CH_NUM_WIDTH,
    parameter int BEATS = DEF_CACHE_STR_WIDTH / DEF_BEAT_WIDTH,
    localparam int BEAT_CNT_W = min1_clog2(BEATS)
) (
    input  logic clk,
    input  logic not_reset,
    input  logic fill_start,
    input  logic [AINDEX_WIDTH-1:0] fill_index,
    input  logic [CH_NUM_WIDTH-1:0] fill_channel,
    input  logic fill_beat_valid,
    output logic req_ready,
    output logic fill_busy,
    output logic fill_done,
    output logic beat_we,
    output logic [BEAT_CNT_W-1:0] beat_sel,
    output logic [AINDEX_WIDTH-1:0] line_index,
    output logic [CH_NUM_WIDTH-1:0] line_channel
);
    fill_state_t state, state_nx;
    logic [BEAT_CNT_W-1:0] cnt, cnt_nx;
    logic [AINDEX_WIDTH-1:0] idx_nx;
    logic [CH_NUM_WIDTH-1:0] ch_nx;

    // state, beat counter and captured target registers
    always_ff @(posedge clk) begin
        if (!not_reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            line_index <= '0;
            line_channel <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            line_index <= idx_nx;
            line_channel <= ch_nx;
        end
    end

    // next state; beats are only consumed while filling
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        idx_nx = line_index;
        ch_nx = line_channel;
        beat_we = 1'b0;
        case (state)
            ST_IDLE: if (fill_start) begin
                state_nx = ST_FILL;
                cnt_nx = '0;
                idx_nx = fill_index;
                ch_nx = fill_channel;
            end
            ST_FILL: if (fill_beat_valid) begin
                beat_we = 1'b1;
                cnt_nx = cnt + 1'b1;
                state_nx = (int'(cnt) == BEATS - 1) ? ST_DONE : ST_FILL;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign beat_sel = cnt;
    assign req_ready = state == ST_IDLE;
    assign fill_busy = state != ST_IDLE;
    assign fill_done = state == ST_DONE;
endmodule

// File: rtl/cache_data_array.sv
// cache_data_array: set/way line storage with byte-masked word access and beat-wise line fill
module cache_data_array
    import cache_data_array_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int AINDEX_WIDTH = DEF_AINDEX_WIDTH,
    parameter int CH_NUM_WIDTH = DEF_CH_NUM_WIDTH,
    parameter int CACHE_STR_WIDTH = DEF_CACHE_STR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
    input logic clk,
    input logic not_reset,
    cache_data_array_if.slave bus
);
    localparam int BANKS = 2 ** AINDEX_WIDTH;
    localparam int BEATS = CACHE_STR_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W = min1_clog2(BEATS);
    localparam int LINES = BANKS * CHANNELS;
    localparam int LINE_W = min1_clog2(LINES);

    if (CACHE_STR_WIDTH % WORD_WIDTH != 0 || CACHE_STR_WIDTH % BEAT_WIDTH != 0 ||
        WORD_WIDTH % 8 != 0 || CHANNELS > 2 ** CH_NUM_WIDTH) begin : g_bad_params
        $error("cache_data_array: illegal parameter combination");
    end

    logic [CACHE_STR_WIDTH-1:0] mem [LINES];
    logic ready, accept, req_hit, fill_ok, beat_we;
    logic [LINE_W-1:0] req_line, fill_line;
    logic [WORD_WIDTH-1:0] old_word, new_word, rsp_word, rdata;
    logic rvalid;
    logic [BEAT_CNT_W-1:0] beat_sel;
    logic [AINDEX_WIDTH-1:0] line_index;
    logic [CH_NUM_WIDTH-1:0] line_channel;

    cache_fill_ctrl #(
        .AINDEX_WIDTH(AINDEX_WIDTH),
        .CH_NUM_WIDTH(CH_NUM_WIDTH),
        .BEATS(BEATS)
    ) u_fill_ctrl (
        .clk(clk),
        .not_reset(not_reset),
        .fill_start(bus.fill_start),
        .fill_index(bus.fill_index),
        .fill_channel(bus.fill_channel),
        .fill_beat_valid(bus.fill_beat_valid),
        .req_ready(ready),
        .fill_busy(bus.fill_busy),
        .fill_done(bus.fill_done),
        .beat_we(beat_we),
        .beat_sel(beat_sel),
        .line_index(line_index),
        .line_channel(line_channel)
    );

    assign bus.req_ready = ready;
    assign accept = bus.req_valid && ready;
    assign req_hit = int'(bus.req_channel) < CHANNELS;
    assign fill_ok = int'(line_channel) < CHANNELS;
    assign req_line = LINE_W'(int'(bus.req_index) * CHANNELS + int'(bus.req_channel));
    assign fill_line = LINE_W'(int'(line_index) * CHANNELS + int'(line_channel));
    assign old_word = mem[req_line][int'(bus.req_offset) * WORD_WIDTH +: WORD_WIDTH];
    assign rsp_word = !req_hit ? '0 : bus.req_write ? new_word : old_word;

    // byte-enable merge of write data over the stored word
    always_comb begin
        new_word = old_word;
        for (int b = 0; b < WORD_WIDTH / 8; b++)
            new_word[b*8 +: 8] = bus.req_be[b] ? bus.req_wdata[b*8 +: 8] : old_word[b*8 +: 8];
    end

    // line storage; CPU writes and fill beats never coincide since access needs IDLE
    always_ff @(posedge clk) begin
        if (!not_reset) begin
            for (int i = 0; i < LINES; i++) mem[i] <= '0;
        end else begin
            if (accept && bus.req_write && req_hit)
                mem[req_line][int'(bus.req_offset) * WORD_WIDTH +: WORD_WIDTH] <= new_word;
            if (beat_we && fill_ok)
                mem[fill_line][int'(beat_sel) * BEAT_WIDTH +: BEAT_WIDTH] <= bus.fill_beat_data;
        end
    end

    // response register; data holds between accesses
    always_ff @(posedge clk) begin
        if (!not_reset) begin
            rvalid <= 1'b0;
            rdata <= '0;
        end else begin
            rvalid <= accept;
            rdata <= accept ? rsp_word : rdata;
        end
    end

    assign bus.rsp_valid = rvalid;
    assign bus.rsp_rdata = rdata;
endmodule
